pa_lsu_sram_arb: RTL and testbench

- Sequencing and arbitration controller in front of the LSU 256x32 single-port SRAM macro.
- Shares the one SRAM port between two requesters:
  - req0: LSU pipeline, high priority.
  - req1: debug/DMA side port, low priority, with anti-starvation.
- Runs a hardware zero-fill sequence after reset or on demand.
- Returns read data one cycle after grant, matching the macro's synchronous read.

---
 rtl/pa_lsu_sram_arb.sv | 153 +++++++++++++++
 tb/tb_pa_lsu_sram_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pa_lsu_sram_arb.sv
// Arbiter and sequencer for the LSU 256x32 single-port SRAM: hardware zero-fill,
// fixed-priority sharing with anti-starvation for the side port, and read return.
module pa_lsu_sram_arb #(
  parameter bit          INIT_EN      = 1'b1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        cpuclk,
  input  logic        cpurst_b,
  input  logic        init_req,
  output logic        init_busy,
  input  logic        req0_vld,
  input  logic        req0_wr,
  input  logic [7:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_be,
  output logic        req0_grnt,
  output logic        req0_rvld,
  output logic [31:0] req0_rdata,
  input  logic        req1_vld,
  input  logic        req1_wr,
  input  logic [7:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_be,
  output logic        req1_grnt,
  output logic        req1_rvld,
  output logic [31:0] req1_rdata,
  output logic [7:0]  sram_a,
  output logic        sram_cen,
  output logic        sram_gwen,
  output logic [31:0] sram_wen,
  output logic [31:0] sram_d,
  input  logic [31:0] sram_q
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam state_e     ST_RESET   = INIT_EN ? ST_INIT : ST_IDLE;

  state_e      state_r, state_s;
  logic [7:0]  init_cnt_r, init_cnt_s;
  logic [3:0]  starve_r, starve_s;
  logic        rvld0_r, rvld1_r;

  // Active-low bit write enables from active-high byte enables.
  function automatic logic [31:0] be_to_wen(input logic [3:0] be);
    logic [31:0] wen;
    for (int i = 0; i < 4; i++) begin
      wen[8*i +: 8] = ~{8{be[i]}};
    end
    return wen;
  endfunction

  // Next-state, arbitration and SRAM port drive.
  always_comb begin
    state_s    = state_r;
    init_cnt_s = init_cnt_r;
    req0_grnt  = 1'b0;
    req1_grnt  = 1'b0;
    sram_cen   = 1'b1;
    sram_gwen  = 1'b1;
    sram_wen   = 32'hFFFF_FFFF;
    sram_a     = 8'h00;
    sram_d     = 32'h0000_0000;
    case (state_r)
      ST_INIT: begin
        sram_cen   = 1'b0;
        sram_gwen  = 1'b0;
        sram_wen   = 32'h0000_0000;
        sram_a     = init_cnt_r;
        init_cnt_s = init_cnt_r + 8'd1;
        if (init_cnt_r == 8'hFF) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (init_req) begin
          state_s = ST_INIT;
        end else if (req1_vld && (starve_r == STARVE_MAX)) begin
          req1_grnt = 1'b1;
        end else if (req0_vld) begin
          req0_grnt = 1'b1;
        end else if (req1_vld) begin
          req1_grnt = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
        // A write with no byte enables still occupies the macro for the cycle.
        if (req0_grnt) begin
          sram_cen  = 1'b0;
          sram_a    = req0_addr;
          sram_d    = req0_wdata;
          sram_gwen = ~req0_wr;
          sram_wen  = req0_wr ? be_to_wen(req0_be) : 32'hFFFF_FFFF;
        end else if (req1_grnt) begin
          sram_cen  = 1'b0;
          sram_a    = req1_addr;
          sram_d    = req1_wdata;
          sram_gwen = ~req1_wr;
          sram_wen  = req1_wr ? be_to_wen(req1_be) : 32'hFFFF_FFFF;
        end else begin
          sram_cen  = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Side-port starvation count; keeps counting through zero-fill.
  always_comb begin
    starve_s = 4'd0;
    if (req1_vld && !req1_grnt) begin
      if (starve_r == STARVE_MAX) begin
        starve_s = starve_r;
      end else begin
        starve_s = starve_r + 4'd1;
      end
    end else begin
      starve_s = 4'd0;
    end
  end

  // State, counters and read-valid registers.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_r    <= ST_RESET;
      init_cnt_r <= 8'd0;
      starve_r   <= 4'd0;
      rvld0_r    <= 1'b0;
      rvld1_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      init_cnt_r <= init_cnt_s;
      starve_r   <= starve_s;
      rvld0_r    <= req0_grnt & ~req0_wr;
      rvld1_r    <= req1_grnt & ~req1_wr;
    end
  end

  assign init_busy  = (state_r == ST_INIT);
  assign req0_rvld  = rvld0_r;
  assign req1_rvld  = rvld1_r;
  assign req0_rdata = rvld0_r ? sram_q : 32'h0000_0000;
  assign req1_rdata = rvld1_r ? sram_q : 32'h0000_0000;

endmodule

// File: tb/tb_pa_lsu_sram_arb.sv
// Scoreboard bench for pa_lsu_sram_arb: directed stimulus, expected read data
// queued per requester and checked by a monitor whenever rvld is presented.
module tb_pa_lsu_sram_arb;

  logic        cpuclk = 1'b0;
  logic        cpurst_b = 1'b0;
  logic        init_req = 1'b0;
  logic        init_busy;
  logic        req0_vld = 1'b0, req0_wr = 1'b0;
  logic [7:0]  req0_addr = 8'h00;
  logic [31:0] req0_wdata = 32'h0;
  logic [3:0]  req0_be = 4'h0;
  logic        req0_grnt, req0_rvld;
  logic [31:0] req0_rdata;
  logic        req1_vld = 1'b0, req1_wr = 1'b0;
  logic [7:0]  req1_addr = 8'h00;
  logic [31:0] req1_wdata = 32'h0;
  logic [3:0]  req1_be = 4'h0;
  logic        req1_grnt, req1_rvld;
  logic [31:0] req1_rdata;
  logic [7:0]  sram_a;
  logic        sram_cen, sram_gwen;
  logic [31:0] sram_wen, sram_d;
  logic [31:0] sram_q = 32'h0;

  logic [31:0] mem [256];
  logic [31:0] exp0_q [$];
  logic [31:0] exp1_q [$];
  int checks = 0;
  int failures = 0;

  always #5 cpuclk = ~cpuclk;

  pa_lsu_sram_arb #(.INIT_EN(1'b1), .STARVE_LIMIT(4)) dut (
    .cpuclk(cpuclk), .cpurst_b(cpurst_b), .init_req(init_req), .init_busy(init_busy),
    .req0_vld(req0_vld), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_grnt(req0_grnt),
    .req0_rvld(req0_rvld), .req0_rdata(req0_rdata),
    .req1_vld(req1_vld), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_grnt(req1_grnt),
    .req1_rvld(req1_rvld), .req1_rdata(req1_rdata),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Behavioural model of the single-port macro (write-then-read, registered q).
  always @(posedge cpuclk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge cpuclk);
    #1;
  endtask

  task automatic set0(input logic v, input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    req0_vld = v; req0_wr = w; req0_addr = a; req0_wdata = d; req0_be = be;
  endtask

  task automatic set1(input logic v, input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    req1_vld = v; req1_wr = w; req1_addr = a; req1_wdata = d; req1_be = be;
  endtask

  task automatic chk_init(input int i);
    chk("init_a", 32'(sram_a), 32'(i));
    chk("init_ctl", 32'({sram_cen, sram_gwen, init_busy, req0_grnt, req1_grnt}), 32'(5'b00100));
    chk("init_wen", sram_wen, 32'h0000_0000);
    chk("init_d", sram_d, 32'h0000_0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      forever begin
        @(negedge cpuclk);
        if (cpurst_b) begin
          if (req0_rvld) begin
            if (exp0_q.size() == 0) chk("rvld0_unexpected", 32'(req0_rvld), 32'd0);
            else chk("rdata0", req0_rdata, exp0_q.pop_front());
          end
          if (req1_rvld) begin
            if (exp1_q.size() == 0) chk("rvld1_unexpected", 32'(req1_rvld), 32'd0);
            else chk("rdata1", req1_rdata, exp1_q.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(negedge cpuclk);
    #1;
    chk("rst_ctl", 32'({init_busy, req0_grnt, req1_grnt, req0_rvld, req1_rvld}), 32'(5'b10000));
    cpurst_b = 1'b1;

    // Power-on zero-fill
    for (int i = 0; i < 256; i++) begin
      #1; chk_init(i); nxt();
    end
    #1; chk("init_done", 32'(init_busy), 32'd0);
    set0(1'b1, 1'b0, 8'h7F, 32'h0, 4'h0);
    #1; chk("rd7f_gnt", 32'(req0_grnt), 32'd1);
    exp0_q.push_back(32'h0000_0000);
    nxt();

    // Partial-byte write then read back
    set0(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 4'b0101);
    #1;
    chk("wr_gnt", 32'(req0_grnt), 32'd1);
    chk("wr_wen", sram_wen, 32'hFF00FF00);
    chk("wr_ctl", 32'({sram_cen, sram_gwen}), 32'd0);
    chk("wr_a", 32'(sram_a), 32'h10);
    chk("wr_d", sram_d, 32'hDEADBEEF);
    nxt();
    set0(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    #1;
    chk("rd_gnt", 32'(req0_grnt), 32'd1);
    chk("rd_ctl", 32'({sram_cen, sram_gwen}), 32'd1);
    chk("rd_wen", sram_wen, 32'hFFFFFFFF);
    exp0_q.push_back(32'h00AD00EF);
    nxt();
    set0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    #1;
    chk("rvld_lat", 32'(req0_rvld), 32'd1);
    chk("idle_drv", 32'({sram_cen, sram_gwen, sram_a}), 32'h300);
    nxt();

    // Preload and simultaneous reads
    set0(1'b1, 1'b1, 8'h01, 32'h11111111, 4'hF); nxt();
    set0(1'b1, 1'b1, 8'h02, 32'h22222222, 4'hF); nxt();
    set0(1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
    set1(1'b1, 1'b0, 8'h02, 32'h0, 4'h0);
    #1;
    chk("sim_gnt_a", 32'({req0_grnt, req1_grnt}), 32'd2);
    exp0_q.push_back(32'h11111111);
    nxt();
    set0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    #1;
    chk("sim_gnt_b", 32'({req0_grnt, req1_grnt}), 32'd1);
    chk("sim_rvld_b", 32'({req0_rvld, req1_rvld}), 32'd2);
    exp1_q.push_back(32'h22222222);
    nxt();
    set1(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    #1;
    chk("sim_rvld_c", 32'({req0_rvld, req1_rvld}), 32'd1);
    nxt();

    // Anti-starvation: req1 forced through every fifth cycle
    set0(1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
    set1(1'b1, 1'b0, 8'h02, 32'h0, 4'h0);
    for (int k = 0; k < 10; k++) begin
      #1;
      if ((k % 5) == 4) begin
        chk("starve_gnt", 32'({req0_grnt, req1_grnt}), 32'd1);
        exp1_q.push_back(32'h22222222);
      end else begin
        chk("starve_gnt", 32'({req0_grnt, req1_grnt}), 32'd2);
        exp0_q.push_back(32'h11111111);
      end
      nxt();
    end
    set0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    set1(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    nxt(); nxt();

    // On-demand zero-fill with a pending request and an ignored re-trigger
    set0(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    init_req = 1'b1;
    #1;
    chk("initreq_gnt", 32'({req0_grnt, req1_grnt, sram_cen}), 32'd1);
    nxt();
    for (int i = 0; i < 256; i++) begin
      init_req = (i == 100);
      #1; chk_init(i); nxt();
    end
    init_req = 1'b0;
    #1;
    chk("reinit_gnt", 32'({init_busy, req0_grnt}), 32'd1);
    exp0_q.push_back(32'h0000_0000);
    nxt();

    // Reset during a pending read return
    set0(1'b1, 1'b0, 8'h01, 32'h0, 4'h0);
    #1; chk("prerst_gnt", 32'(req0_grnt), 32'd1);
    @(posedge cpuclk); #1;
    chk("prerst_rvld", 32'(req0_rvld), 32'd1);
    cpurst_b = 1'b0;
    #1;
    chk("rst_rvld", 32'({req0_rvld, req0_rdata}), 32'd0);
    set0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    nxt();
    cpurst_b = 1'b1;

    // Reset in the middle of zero-fill restarts from address 0
    for (int i = 0; i <= 128; i++) begin
      #1; chk_init(i);
      if (i != 128) nxt();
    end
    cpurst_b = 1'b0;
    #1;
    chk("midinit_rst", 32'({init_busy, sram_a}), 32'h100);
    nxt();
    cpurst_b = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #1; chk_init(i); nxt();
    end
    set0(1'b1, 1'b0, 8'h7F, 32'h0, 4'h0);
    #1; chk("final_gnt", 32'({init_busy, req0_grnt}), 32'd1);
    exp0_q.push_back(32'h0000_0000);
    nxt();
    set0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    nxt(); nxt();
    chk("queues_empty", 32'(exp0_q.size() + exp1_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
